// File: rtl/ads131a0x_spi_responder_if.sv
// SPI pin bundle between the ADS131A0x driver (master) and the emulated ADC (slave).
//   SPI_SCLK  : serial clock, CPOL=0 / CPHA=1, driven by master
//   SPI_CS    : active-low chip select, driven by master
//   SPI_MOSI  : command data, driven by master
//   SPI_RESET : active-low ADC hardware reset, driven by master
//   SPI_MISO  : response data, driven by slave
//   SPI_DRDY  : active-low data ready, driven by slave
interface ads131a0x_spi_responder_if;
  logic SPI_SCLK;
  logic SPI_CS;
  logic SPI_MOSI;
  logic SPI_RESET;
  logic SPI_MISO;
  logic SPI_DRDY;

  modport master (
    output SPI_SCLK, SPI_CS, SPI_MOSI, SPI_RESET,
    input  SPI_MISO, SPI_DRDY
  );

  modport slave (
    input  SPI_SCLK, SPI_CS, SPI_MOSI, SPI_RESET,
    output SPI_MISO, SPI_DRDY
  );
endinterface

// File: rtl/ads131a0x_spi_responder.sv
// ADS131A0x emulator: SPI slave returning status + channel words and a DRDY timer.
//   system_clock : system clock (50 MHz)
//   reset        : synchronous active-high reset
//   spi          : SPI pin bundle (slave side)
//   frame_count  : conversion counter (debug)
//   last_cmd     : last executed command word (debug)
//   drdy_overrun : sticky, conversion while DRDY still low; cleared on CS fall
module ads131a0x_spi_responder #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WORD_BITS   = 32,
  parameter int unsigned DRDY_PERIOD = 5000
) (
  input  logic                     system_clock,
  input  logic                     reset,
  ads131a0x_spi_responder_if.slave spi,
  output logic [19:0]              frame_count,
  output logic [15:0]              last_cmd,
  output logic                     drdy_overrun
);
  localparam int unsigned BCW  = $clog2(WORD_BITS);
  localparam int unsigned WIW  = $clog2(NUM_CH + 3);
  localparam int unsigned TW   = $clog2(DRDY_PERIOD);
  localparam int unsigned PADW = WORD_BITS - 16;
  localparam int unsigned SMPW = WORD_BITS - 24;
  localparam logic [TW-1:0] TMR_RELOAD = TW'(DRDY_PERIOD - 1);
  localparam logic [15:0] RESP_READY  = 16'hFF04;
  localparam logic [15:0] CMD_NULL    = 16'h0000;
  localparam logic [15:0] CMD_RESET   = 16'h0011;
  localparam logic [15:0] CMD_UNLOCK  = 16'h0655;
  localparam logic [15:0] CMD_LOCK    = 16'h0555;
  localparam logic [15:0] CMD_WAKEUP  = 16'h0033;
  localparam logic [15:0] CMD_STANDBY = 16'h0022;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_e;
  state_e state_q, state_d;

  logic [2:0]           sclk_sq, cs_sq;
  logic [1:0]           mosi_sq, rstn_sq;
  logic                 miso_q, drdy_q, ovr_q, locked_q, awake_q, pend_q, samp_vld_q;
  logic                 w0_done_q, soft_rst_q;
  logic [19:0]          fc_q, samp_fc_q;
  logic [15:0]          resp_q, cmd_q, last_cmd_q;
  logic [7:0]           regs_q [32];
  logic [WORD_BITS-1:0] tx_q;
  logic [WORD_BITS-2:0] rx_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic [WIW-1:0]       word_idx_q;
  logic [TW-1:0]        tmr_q;

  // Pin synchronizers; stage [2] is the delayed copy used for edge detect.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      sclk_sq <= '0;
      cs_sq   <= '1;
      mosi_sq <= '0;
      rstn_sq <= '1;
    end else begin
      sclk_sq <= {sclk_sq[1:0], spi.SPI_SCLK};
      cs_sq   <= {cs_sq[1:0], spi.SPI_CS};
      mosi_sq <= {mosi_sq[0], spi.SPI_MOSI};
      rstn_sq <= {rstn_sq[0], spi.SPI_RESET};
    end
  end

  logic sclk_rise_c, sclk_fall_c, cs_fall_c, rst_hw_c, rst_all_c;
  assign sclk_rise_c = sclk_sq[1] & ~sclk_sq[2];
  assign sclk_fall_c = ~sclk_sq[1] & sclk_sq[2];
  assign cs_fall_c   = ~cs_sq[1] & cs_sq[2];
  assign rst_hw_c    = reset | ~rstn_sq[1];
  // The RESET command lands one cycle after DONE through soft_rst_q.
  assign rst_all_c   = rst_hw_c | soft_rst_q;

  // Command decode and lock filtering.
  logic [4:0] addr_c;
  logic [7:0] wdata_c;
  logic is_null_c, is_rst_c, is_unlock_c, is_lock_c, is_wake_c, is_stby_c;
  logic is_rreg_c, is_wreg_c, known_c, allowed_c, exec_c, stby_exec_c;
  assign addr_c      = cmd_q[12:8];
  assign wdata_c     = cmd_q[7:0];
  assign is_null_c   = (cmd_q == CMD_NULL);
  assign is_rst_c    = (cmd_q == CMD_RESET);
  assign is_unlock_c = (cmd_q == CMD_UNLOCK);
  assign is_lock_c   = (cmd_q == CMD_LOCK);
  assign is_wake_c   = (cmd_q == CMD_WAKEUP);
  assign is_stby_c   = (cmd_q == CMD_STANDBY);
  assign is_rreg_c   = (cmd_q[15:13] == 3'b001);
  assign is_wreg_c   = (cmd_q[15:13] == 3'b010);
  assign known_c     = is_null_c | is_rst_c | is_unlock_c | is_lock_c | is_wake_c |
                       is_stby_c | is_rreg_c | is_wreg_c;
  assign allowed_c   = ~locked_q | is_null_c | is_unlock_c | is_rst_c | is_rreg_c;
  assign exec_c      = (state_q == ST_DONE) && w0_done_q && known_c && allowed_c;
  assign stby_exec_c = exec_c && is_stby_c;

  // Conversion events latch immediately with CS high, otherwise wait for CS rise.
  logic tmr_evt_c, do_latch_c;
  assign tmr_evt_c  = awake_q && (tmr_q == '0);
  assign do_latch_c = (tmr_evt_c && (state_q == ST_IDLE) && !cs_fall_c) ||
                      ((state_q == ST_DONE) && (pend_q || tmr_evt_c) && !stby_exec_c);

  // Shift datapath helpers: MSB-first receive, next data word to transmit.
  logic [WORD_BITS-1:0] rx_next_c, data_word_c;
  logic [WIW-1:0]       next_idx_c;
  assign rx_next_c   = {rx_q, mosi_sq[1]};
  assign next_idx_c  = word_idx_q + WIW'(1);
  assign data_word_c = (samp_vld_q && (next_idx_c <= WIW'(NUM_CH))) ?
                       {samp_fc_q, 4'(next_idx_c - WIW'(1)), SMPW'(0)} : '0;

  // Frame state register.
  always_ff @(posedge system_clock) begin
    if (rst_all_c) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Frame next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cs_fall_c) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (cs_sq[1]) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Debug command register and deferred soft reset survive the soft reset itself.
  always_ff @(posedge system_clock) begin
    if (rst_hw_c) begin
      last_cmd_q <= '0;
      soft_rst_q <= 1'b0;
    end else begin
      soft_rst_q <= exec_c && is_rst_c;
      if (exec_c) last_cmd_q <= cmd_q;
    end
  end

  // Main datapath: timer, sample latch, shifter and command execution.
  always_ff @(posedge system_clock) begin
    if (rst_all_c) begin
      miso_q     <= 1'b0;
      drdy_q     <= 1'b1;
      ovr_q      <= 1'b0;
      fc_q       <= '0;
      resp_q     <= RESP_READY;
      locked_q   <= 1'b1;
      awake_q    <= 1'b0;
      pend_q     <= 1'b0;
      samp_vld_q <= 1'b0;
      samp_fc_q  <= '0;
      tmr_q      <= TMR_RELOAD;
      tx_q       <= '0;
      rx_q       <= '0;
      cmd_q      <= '0;
      w0_done_q  <= 1'b0;
      bit_cnt_q  <= '0;
      word_idx_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      tmr_q <= (!awake_q || tmr_q == '0) ? TMR_RELOAD : tmr_q - TW'(1);
      if (do_latch_c) begin
        fc_q       <= fc_q + 20'd1;
        samp_fc_q  <= fc_q + 20'd1;
        samp_vld_q <= 1'b1;
        drdy_q     <= 1'b0;
        pend_q     <= 1'b0;
        if (!drdy_q) ovr_q <= 1'b1;
      end else if (tmr_evt_c && !stby_exec_c) begin
        pend_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: miso_q <= 1'b0;
        ST_LOAD: begin
          tx_q       <= {resp_q, PADW'(0)};
          miso_q     <= resp_q[15];
          bit_cnt_q  <= '0;
          word_idx_q <= '0;
          w0_done_q  <= 1'b0;
          drdy_q     <= 1'b1;
          ovr_q      <= 1'b0;
        end
        ST_SHIFT: begin
          // Each rise presents the current MSB, so bit 31 is valid for the first fall.
          if (sclk_rise_c) begin
            miso_q <= tx_q[WORD_BITS-1];
            tx_q   <= {tx_q[WORD_BITS-2:0], 1'b0};
          end
          if (sclk_fall_c) begin
            rx_q <= rx_next_c[WORD_BITS-2:0];
            if (bit_cnt_q == BCW'(WORD_BITS - 1)) begin
              bit_cnt_q <= '0;
              tx_q      <= data_word_c;
              if (word_idx_q == '0) begin
                cmd_q     <= rx_next_c[WORD_BITS-1 -: 16];
                w0_done_q <= 1'b1;
              end
              if (word_idx_q <= WIW'(NUM_CH)) word_idx_q <= next_idx_c;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end
        ST_DONE: begin
          miso_q <= 1'b0;
          if (exec_c) begin
            if (is_null_c)      resp_q <= {8'h22, regs_q[2]};
            else if (is_rreg_c) resp_q <= {3'b001, addr_c, regs_q[addr_c]};
            else if (is_wreg_c) begin
              regs_q[addr_c] <= wdata_c;
              resp_q         <= {3'b001, addr_c, wdata_c};
            end else            resp_q <= cmd_q;
            if (is_unlock_c) locked_q <= 1'b0;
            if (is_lock_c)   locked_q <= 1'b1;
            if (is_wake_c)   awake_q  <= 1'b1;
            if (is_stby_c)   awake_q  <= 1'b0;
          end
        end
        default: miso_q <= 1'b0;
      endcase
    end
  end

  assign spi.SPI_MISO = miso_q;
  assign spi.SPI_DRDY = drdy_q;
  assign frame_count  = fc_q;
  assign last_cmd     = last_cmd_q;
  assign drdy_overrun = ovr_q;
endmodule

// File: tb/tb_ads131a0x_spi_responder.sv
// Directed + randomized bench for the ADS131A0x SPI responder with a behavioural model.
module tb_ads131a0x_spi_responder;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned WB     = 32;
  localparam int unsigned DP     = 3000;
  localparam int unsigned NW     = NUM_CH + 1;

  logic clk = 1'b0;
  logic rst;
  logic [19:0] frame_count;
  logic [15:0] last_cmd;
  logic drdy_overrun;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ads131a0x_spi_responder_if spi_if();

  ads131a0x_spi_responder #(.NUM_CH(NUM_CH), .WORD_BITS(WB), .DRDY_PERIOD(DP)) dut (
    .system_clock (clk),
    .reset        (rst),
    .spi          (spi_if.slave),
    .frame_count  (frame_count),
    .last_cmd     (last_cmd),
    .drdy_overrun (drdy_overrun)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] rxw [NW];

  // Reference model state
  logic [15:0] m_resp, m_last;
  logic        m_locked;
  logic [7:0]  m_reg [32];
  logic [19:0] m_samp;
  logic        m_vld;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic void m_reset();
    m_resp = 16'hFF04; m_last = 16'h0000; m_locked = 1'b1;
    m_samp = '0; m_vld = 1'b0;
    for (int i = 0; i < 32; i++) m_reg[i] = 8'h00;
  endfunction

  function automatic void m_exec(input logic [15:0] c);
    logic [4:0] a;
    logic [7:0] d;
    logic rreg, wreg, known, ok;
    a = c[12:8]; d = c[7:0];
    rreg  = (c[15:13] == 3'b001);
    wreg  = (c[15:13] == 3'b010);
    known = rreg || wreg || (c inside {16'h0000, 16'h0011, 16'h0655, 16'h0555, 16'h0033, 16'h0022});
    ok    = known && (!m_locked || rreg || (c inside {16'h0000, 16'h0655, 16'h0011}));
    if (!ok) return;
    if (c == 16'h0000) m_resp = {8'h22, m_reg[2]};
    else if (c == 16'h0011) m_reset();
    else if (rreg) m_resp = {3'b001, a, m_reg[a]};
    else if (wreg) begin m_reg[a] = d; m_resp = {3'b001, a, d}; end
    else begin
      m_resp = c;
      if (c == 16'h0655) m_locked = 1'b0;
      if (c == 16'h0555) m_locked = 1'b1;
    end
    m_last = c;
  endfunction

  function automatic logic [31:0] m_word(input int k);
    if (k == 0) return {m_resp, 16'h0000};
    if (!m_vld) return 32'h0;
    return {m_samp, 4'(k - 1), 8'h00};
  endfunction

  // One SPI frame of nbits; optional SPI_RESET pulse before bit rst_at.
  task automatic frame(input logic [15:0] cmd, input int nbits, input int rst_at);
    logic [WB-1:0] mo;
    mo = {cmd, 16'h0000};
    for (int w = 0; w < NW; w++) rxw[w] = '0;
    spi_if.SPI_CS = 1'b0;
    tick(6);
    for (int b = 0; b < nbits; b++) begin
      if (b == rst_at) begin
        spi_if.SPI_RESET = 1'b0;
        tick(4);
        chk("spirst_miso", 32'(spi_if.SPI_MISO), 32'h0);
        chk("spirst_drdy", 32'(spi_if.SPI_DRDY), 32'h1);
        chk("spirst_fc", 32'(frame_count), 32'h0);
        chk("spirst_last", 32'(last_cmd), 32'h0);
        spi_if.SPI_RESET = 1'b1;
        tick(4);
      end
      spi_if.SPI_MOSI = (b < int'(WB)) ? mo[WB-1-b] : 1'b0;
      spi_if.SPI_SCLK = 1'b1;
      tick(4);
      rxw[b / WB] = {rxw[b / WB][WB-2:0], spi_if.SPI_MISO};
      spi_if.SPI_SCLK = 1'b0;
      tick(4);
    end
    spi_if.SPI_CS = 1'b1;
    tick(10);
  endtask

  task automatic frame_chk(input logic [15:0] cmd, input string tag);
    logic [31:0] ew [NW];
    for (int k = 0; k < NW; k++) ew[k] = m_word(k);
    frame(cmd, NW * WB, -1);
    for (int k = 0; k < NW; k++) chk($sformatf("%s_w%0d", tag, k), rxw[k], ew[k]);
    m_exec(cmd);
    chk({tag, "_last"}, 32'(last_cmd), 32'(m_last));
  endtask

  function automatic logic hit(input int which);
    if (which == 0) return spi_if.SPI_DRDY === 1'b0;
    return drdy_overrun === 1'b1;
  endfunction

  task automatic wait_for(input int which, input int bound, output int at_cyc);
    int n;
    n = 0;
    while (!hit(which) && n < bound) begin tick(1); n++; end
    at_cyc = cyc;
  endtask

  initial begin
    logic [15:0] c;
    logic [31:0] e;
    int t1, t2, t3, r;

    spi_if.SPI_SCLK = 1'b0; spi_if.SPI_CS = 1'b1;
    spi_if.SPI_MOSI = 1'b0; spi_if.SPI_RESET = 1'b1;
    rst = 1'b1;
    m_reset();
    tick(5);
    chk("rst_miso", 32'(spi_if.SPI_MISO), 32'h0);
    chk("rst_drdy", 32'(spi_if.SPI_DRDY), 32'h1);
    chk("rst_fc", 32'(frame_count), 32'h0);
    chk("rst_last", 32'(last_cmd), 32'h0);
    chk("rst_ovr", 32'(drdy_overrun), 32'h0);
    rst = 1'b0;
    tick(5);

    // First frame after reset reports READY, no samples yet
    frame_chk(16'h0000, "f0");
    chk("f0_ready", rxw[0], 32'hFF040000);
    chk("f0_drdy", 32'(spi_if.SPI_DRDY), 32'h1);

    // Locked: WREG ignored, RREG allowed
    frame_chk(16'h425A, "lk_wreg");
    frame_chk(16'h2200, "lk_rreg");
    frame_chk(16'h0000, "lk_null");
    chk("lk_reg2", rxw[0], 32'h22000000);

    // Unlocked register access
    frame_chk(16'h0655, "ul");
    frame_chk(16'h425A, "ul_wreg");
    chk("ul_echo", rxw[0], 32'h06550000);
    frame_chk(16'h2200, "ul_rreg");
    chk("ul_wresp", rxw[0], 32'h225A0000);
    frame_chk(16'h0000, "ul_null");
    chk("ul_rresp", rxw[0], 32'h225A0000);
    frame_chk(16'h0000, "ul_null2");
    chk("ul_nresp", rxw[0], 32'h225A0000);

    // Randomized register traffic
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: c = 16'h0000;
        1: c = {3'b010, 5'($urandom), 8'($urandom)};
        2: c = {3'b001, 5'($urandom), 8'($urandom)};
        3: c = 16'h0555;
        default: c = 16'h0655;
      endcase
      frame_chk(c, $sformatf("rnd%0d", i));
    end

    // Aborted frame: command discarded, response unchanged
    frame_chk(16'h0655, "ab_ul");
    e = m_word(0);
    frame(16'h4277, 10, -1);
    chk("ab_w0", rxw[0], 32'(e[31:22]));
    chk("ab_last", 32'(last_cmd), 32'h0655);
    frame_chk(16'h2200, "ab_rreg");
    chk("ab_resp", rxw[0], 32'h06550000);
    frame_chk(16'h0000, "ab_null");

    // Conversion timer
    frame_chk(16'h0033, "wk");
    wait_for(0, DP + 200, t1);
    chk("drdy_fall1", 32'(spi_if.SPI_DRDY), 32'h0);
    chk("fc1", 32'(frame_count), 32'h1);
    m_samp = 20'd1; m_vld = 1'b1;
    frame_chk(16'h0000, "rd1");
    chk("rd1_ch0", rxw[1], 32'h00001000);
    chk("rd1_ch3", rxw[4], 32'h00001300);
    chk("rd1_drdy", 32'(spi_if.SPI_DRDY), 32'h1);
    wait_for(0, DP + 200, t2);
    chk("drdy_fall2", 32'(spi_if.SPI_DRDY), 32'h0);
    chk("drdy_period", 32'(t2 - t1), 32'(DP));
    chk("ovr_clear", 32'(drdy_overrun), 32'h0);
    wait_for(1, DP + 200, t3);
    chk("ovr_set", 32'(drdy_overrun), 32'h1);
    chk("fc3", 32'(frame_count), 32'h3);
    chk("ovr_period", 32'(t3 - t2), 32'(DP));
    m_samp = 20'd3;
    frame_chk(16'h0022, "sb");
    chk("sb_ovr", 32'(drdy_overrun), 32'h0);
    chk("sb_ch1", rxw[2], 32'h00003100);
    tick(DP + 200);
    chk("sb_drdy", 32'(spi_if.SPI_DRDY), 32'h1);
    chk("sb_fc", 32'(frame_count), 32'h3);

    // SPI_RESET pulse mid-frame
    frame(16'h0000, NW * WB, 40);
    m_reset();
    chk("spirst_w2", rxw[2], 32'h0);
    chk("spirst_w4", rxw[4], 32'h0);
    frame_chk(16'h0000, "pr");
    chk("pr_ready", rxw[0], 32'hFF040000);
    frame_chk(16'h4211, "pr_lk");
    frame_chk(16'h0000, "pr_null");
    chk("pr_reg2", rxw[0], 32'h22000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
